discharge_pulse_sort: RTL and testbench
=======================================

// Module: discharge_pulse_sort
// PURPOSE
//  Per-pulse gap-state classifier downstream of discharge_control. Watches the gated PWM on-window and the ADC sample stream.
//  Each pulse is classified as NORMAL, ARC, SHORT or OPEN, and the ignition delay is measured.
//  Drives pro1_short_flag back into discharge_control/PWM, with hysteresis, to cut pulses during sustained shorts.
// PARAMETERS
//  I_BREAK   16'd400  current code at/above which the gap counts as broken down
//  V_SHORT   16'd300  voltage code at/below which a broken-down gap counts as shorted
//  T_ARC     16'd50   ignition delay (clk cycles) below which a non-short pulse is ARC
//  SHORT_SET 8'd3     consecutive SHORT pulses that set pro1_short_flag
//  SHORT_CLR 8'd5     consecutive non-SHORT pulses that clear pro1_short_flag
// PORTS
//  clk              in  1   system clock, 50 MHz
//  rst_n            in  1   asynchronous active-low reset
//  start            in  1   classifier enable; low forces IDLE
//  pwm_on           in  1   OR of PWM[7:0]; high for the whole pulse on-time
//  sample_valid     in  1   sample_data qualifier
//  sample_data      in  32  {current[31:16], voltage[15:0]}, unsigned
//  pulse_valid      out 1   one-cycle strobe; class/delay are valid
//  pulse_class      out 2   00 NORMAL, 01 ARC, 10 SHORT, 11 OPEN
//  ign_delay        out 16  cycles from on-window start to breakdown sample
//  pro1_short_flag  out 1   sustained-short indication
//  stats_clr        in  1   (PULSE_SORT_STATS_EN only) sync clear of counters
//  cnt_normal/cnt_arc/cnt_short/cnt_open out 16 each (PULSE_SORT_STATS_EN only)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; delay counter, hysteresis counters and statistics counters 0.
//  FSM:
//   IDLE       -> WAIT_BREAK when start & pwm_on; delay_cnt<=0.
//   WAIT_BREAK -> delay_cnt++ every cycle, saturating at 16'hFFFF.
//      On sample_valid & current>=I_BREAK: latch class and delay, then go to IGNITED.
//        voltage<=V_SHORT -> SHORT
//        else delay_cnt<T_ARC -> ARC
//        else NORMAL
//      Else, on pwm_on low: class=OPEN, delay=16'hFFFF, go to REPORT.
//      If breakdown and pwm_on-low occur in the same cycle, breakdown wins and the FSM goes straight to REPORT.
//   IGNITED    -> REPORT when pwm_on low. Later samples do not change the class.
//   REPORT     -> one cycle: pulse_valid=1; pulse_class/ign_delay are registered outputs, held until the next REPORT.
//      Next state is WAIT_BREAK (delay_cnt<=0) if start & pwm_on, else IDLE.
//  Latency: pulse_valid asserts 1 cycle after the pwm_on falling edge is sampled. An OPEN pulse produces exactly one report.
//  Hysteresis, updated only in REPORT:
//   SHORT: clr_cnt<=0; set_cnt++ saturating; flag<=1 once set_cnt+1>=SHORT_SET.
//   Other classes: set_cnt<=0; clr_cnt++ saturating; flag<=0 once clr_cnt+1>=SHORT_CLR.
//  start low, any state: next cycle IDLE; pulse in progress is discarded with no report; flag and hysteresis counters cleared; stats kept.
//  sample_valid low: the sample is ignored; timing still advances.
// CONFIGURATION
//  PULSE_SORT_STATS_EN defined:
//   - Four 16-bit per-class counters, each +1 on its REPORT, saturating at 16'hFFFF.
//   - stats_clr zeroes all four; stats_clr in the same cycle as REPORT leaves the reporting counter at 0.
//  PULSE_SORT_STATS_EN undefined: the counter ports and stats_clr are absent; no counter logic.
// STRUCTURE
//  Shared header discharge_defs.vh:
//   - class codes CLS_NORMAL/CLS_ARC/CLS_SHORT/CLS_OPEN
//   - FSM state encodings
//   - sample field slices CUR_MSB/CUR_LSB/VOL_MSB/VOL_LSB
//  One sub-module sat_counter (WIDTH param, inc, clr), reused for the delay, hysteresis and statistics counters.
// TESTING
//  T1 pwm_on high 200 cyc; current 500 @ cycle 80; voltage 600
//     -> NORMAL, ign_delay=80, pulse_valid 1 cyc after the pwm_on fall.
//  T2 breakdown @ cycle 20, voltage 600 -> ARC, ign_delay=20.
//     Repeat with voltage 200 -> SHORT regardless of delay.
//  T3 pwm_on 200 cyc, current never >=400 -> OPEN, ign_delay=FFFF; exactly one strobe.
//  T4 SHORT,SHORT,NORMAL,SHORT,SHORT,SHORT -> flag rises at the 6th report.
//     Then 4 NORMAL -> flag stays 1; 5th NORMAL -> flag 0.
//  T5 start low mid-IGNITED -> no strobe; flag 0; next pulse classified normally.
//     Breakdown coincident with pwm_on fall -> reported as breakdown class, not OPEN.
//  T6 (STATS_EN) 3 ARC -> cnt_arc=3; stats_clr coincident with the 4th ARC -> cnt_arc=0.

Source files
------------

// File: rtl/discharge_pulse_sort_pkg.sv
// Shared definitions for the discharge pulse classifier: class codes, FSM
// state encoding, sample field slices and the per-pulse classification rule.
// Imported by discharge_pulse_sort and discharge_pulse_sort_sat_counter users.
package discharge_pulse_sort_pkg;

    // Pulse class codes as seen on pulse_class.
    localparam logic [1:0] CLS_NORMAL = 2'b00;
    localparam logic [1:0] CLS_ARC    = 2'b01;
    localparam logic [1:0] CLS_SHORT  = 2'b10;
    localparam logic [1:0] CLS_OPEN   = 2'b11;

    // Classifier FSM states.
    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_BREAK = 2'd1,
        ST_IGNITED    = 2'd2,
        ST_REPORT     = 2'd3
    } state_t;

    // sample_data = {current, voltage}.
    localparam int CUR_MSB = 31;
    localparam int CUR_LSB = 16;
    localparam int VOL_MSB = 15;
    localparam int VOL_LSB = 0;

    // Class of a broken-down pulse. A low gap voltage marks a short no matter
    // how quickly the gap fired; otherwise a fast ignition is an arc.
    function automatic logic [1:0] classify(input logic [15:0] vol,
                                            input logic [15:0] dly,
                                            input logic [15:0] v_short,
                                            input logic [15:0] t_arc);
        logic [1:0] cls;
        if (vol <= v_short)
            cls = CLS_SHORT;
        else if (dly < t_arc)
            cls = CLS_ARC;
        else
            cls = CLS_NORMAL;
        return cls;
    endfunction

endpackage

// File: rtl/discharge_pulse_sort_sat_counter.sv
// Purpose: saturating up-counter with synchronous clear (clear has priority).
// Latency: q reflects inc/clr one clock after they are sampled.
// Backpressure: none; counts every enabled cycle, sticks at all-ones.
// Ports: clk, rst_n (async active-low), clr, inc, q[WIDTH-1:0].
module discharge_pulse_sort_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (clr)
            q <= '0;
        else if (inc && (q != '1))
            q <= q + ONE;
    end

endmodule

// File: rtl/discharge_pulse_sort.sv
// Purpose: classifies each gated PWM pulse as NORMAL/ARC/SHORT/OPEN, measures
//          ignition delay and drives pro1_short_flag with set/clear hysteresis.
// Latency: pulse_valid strobes 1 clk after pwm_on low is sampled; backpressure: none.
// Ports: clk, rst_n, start, pwm_on, sample_valid, sample_data[31:0] in;
//        pulse_valid, pulse_class[1:0], ign_delay[15:0], pro1_short_flag out.
//        With PULSE_SORT_STATS_EN defined: stats_clr in, cnt_normal/cnt_arc/
//        cnt_short/cnt_open[15:0] out (per-class saturating report counters).
module discharge_pulse_sort
    import discharge_pulse_sort_pkg::*;
#(
    parameter logic [15:0] I_BREAK   = 16'd400,
    parameter logic [15:0] V_SHORT   = 16'd300,
    parameter logic [15:0] T_ARC     = 16'd50,
    parameter logic [7:0]  SHORT_SET = 8'd3,
    parameter logic [7:0]  SHORT_CLR = 8'd5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pwm_on,
    input  logic        sample_valid,
    input  logic [31:0] sample_data,
    output logic        pulse_valid,
    output logic [1:0]  pulse_class,
    output logic [15:0] ign_delay,
    output logic        pro1_short_flag
`ifdef PULSE_SORT_STATS_EN
    ,
    input  logic        stats_clr,
    output logic [15:0] cnt_normal,
    output logic [15:0] cnt_arc,
    output logic [15:0] cnt_short,
    output logic [15:0] cnt_open
`endif
);

    state_t      state, state_nxt;
    logic [15:0] delay_cnt, delay_step;
    logic        delay_clr, delay_inc;
    logic [15:0] cur, vol;
    logic        brk;
    logic [1:0]  brk_cls, held_cls, rpt_cls;
    logic [15:0] held_dly, rpt_dly;
    logic        brk_load, rpt_load;
    logic        in_report, is_short;
    logic [7:0]  set_cnt, clr_cnt;
    logic [8:0]  set_p1, clr_p1;

    assign cur = sample_data[CUR_MSB:CUR_LSB];
    assign vol = sample_data[VOL_MSB:VOL_LSB];
    assign brk = sample_valid && (cur >= I_BREAK);

    // The delay reported for a breakdown sampled this cycle is the count after
    // this cycle's increment, so it equals cycles since the on-window began.
    assign delay_step = (delay_cnt == 16'hFFFF) ? delay_cnt : delay_cnt + 16'd1;
    assign brk_cls    = classify(vol, delay_step, V_SHORT, T_ARC);

    discharge_pulse_sort_sat_counter #(.WIDTH(16)) u_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (delay_clr),
        .inc   (delay_inc),
        .q     (delay_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        delay_clr = 1'b0;
        delay_inc = 1'b0;
        brk_load  = 1'b0;
        rpt_load  = 1'b0;
        rpt_cls   = held_cls;
        rpt_dly   = held_dly;
        if (!start) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pwm_on) begin
                        state_nxt = ST_WAIT_BREAK;
                        delay_clr = 1'b1;
                    end
                end
                ST_WAIT_BREAK: begin
                    delay_inc = 1'b1;
                    if (brk) begin
                        brk_load = 1'b1;
                        // Breakdown on the last on-cycle still counts as a fire.
                        if (!pwm_on) begin
                            state_nxt = ST_REPORT;
                            rpt_load  = 1'b1;
                            rpt_cls   = brk_cls;
                            rpt_dly   = delay_step;
                        end else begin
                            state_nxt = ST_IGNITED;
                        end
                    end else if (!pwm_on) begin
                        state_nxt = ST_REPORT;
                        rpt_load  = 1'b1;
                        rpt_cls   = CLS_OPEN;
                        rpt_dly   = 16'hFFFF;
                    end
                end
                ST_IGNITED: begin
                    if (!pwm_on) begin
                        state_nxt = ST_REPORT;
                        rpt_load  = 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (pwm_on) begin
                        state_nxt = ST_WAIT_BREAK;
                        delay_clr = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Class/delay of the pulse in flight; copied to the outputs only on report
    // so the outputs stay stable between reports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_cls <= CLS_NORMAL;
            held_dly <= 16'd0;
        end else if (brk_load) begin
            held_cls <= brk_cls;
            held_dly <= delay_step;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_valid <= 1'b0;
            pulse_class <= CLS_NORMAL;
            ign_delay   <= 16'd0;
        end else begin
            pulse_valid <= rpt_load;
            if (rpt_load) begin
                pulse_class <= rpt_cls;
                ign_delay   <= rpt_dly;
            end
        end
    end

    // Hysteresis runs off the reported class during the REPORT cycle.
    assign in_report = (state == ST_REPORT);
    assign is_short  = (pulse_class == CLS_SHORT);

    discharge_pulse_sort_sat_counter #(.WIDTH(8)) u_set (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!start || (in_report && !is_short)),
        .inc   (in_report && is_short),
        .q     (set_cnt)
    );

    discharge_pulse_sort_sat_counter #(.WIDTH(8)) u_clr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!start || (in_report && is_short)),
        .inc   (in_report && !is_short),
        .q     (clr_cnt)
    );

    assign set_p1 = {1'b0, set_cnt} + 9'd1;
    assign clr_p1 = {1'b0, clr_cnt} + 9'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pro1_short_flag <= 1'b0;
        else if (!start)
            pro1_short_flag <= 1'b0;
        else if (in_report) begin
            if (is_short && (set_p1 >= {1'b0, SHORT_SET}))
                pro1_short_flag <= 1'b1;
            else if (!is_short && (clr_p1 >= {1'b0, SHORT_CLR}))
                pro1_short_flag <= 1'b0;
        end
    end

`ifdef PULSE_SORT_STATS_EN
    // Statistics survive start going low; only reset and stats_clr zero them.
    logic [15:0] stat_q [4];

    for (genvar k = 0; k < 4; k++) begin : g_stat
        discharge_pulse_sort_sat_counter #(.WIDTH(16)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (stats_clr),
            .inc   (in_report && (pulse_class == 2'(k))),
            .q     (stat_q[k])
        );
    end

    assign cnt_normal = stat_q[0];
    assign cnt_arc    = stat_q[1];
    assign cnt_short  = stat_q[2];
    assign cnt_open   = stat_q[3];
`endif

endmodule

// File: tb/tb_discharge_pulse_sort.sv
// Bench for discharge_pulse_sort: pulse-level stimulus with an expected-report
// queue, run-length hysteresis model and per-class counts, checked every cycle.
module tb_discharge_pulse_sort;

    localparam logic [1:0] C_N = 2'b00;
    localparam logic [1:0] C_A = 2'b01;
    localparam logic [1:0] C_S = 2'b10;
    localparam logic [1:0] C_O = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n, start, pwm_on, sample_valid, stats_clr;
    logic [31:0] sample_data;
    logic        pulse_valid, pro1_short_flag;
    logic [1:0]  pulse_class;
    logic [15:0] ign_delay;
`ifdef PULSE_SORT_STATS_EN
    logic [15:0] cnt_normal, cnt_arc, cnt_short, cnt_open;
`endif

    discharge_pulse_sort dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .pwm_on          (pwm_on),
        .sample_valid    (sample_valid),
        .sample_data     (sample_data),
        .pulse_valid     (pulse_valid),
        .pulse_class     (pulse_class),
        .ign_delay       (ign_delay),
        .pro1_short_flag (pro1_short_flag)
`ifdef PULSE_SORT_STATS_EN
        ,
        .stats_clr       (stats_clr),
        .cnt_normal      (cnt_normal),
        .cnt_arc         (cnt_arc),
        .cnt_short       (cnt_short),
        .cnt_open        (cnt_open)
`endif
    );

    always #10 clk = ~clk;

    int   cyc = 0;
    logic st_q = 1'b0;
    logic sc_q = 1'b0;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        st_q <= start;
        sc_q <= stats_clr;
    end

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int          cyc;
        logic [1:0]  cls;
        logic [15:0] dly;
    } rpt_t;
    rpt_t rq[$];

    // Expected report of a pulse whose breakdown sample sits brk cycles after
    // the on-window start (brk == 0: the gap never broke down).
    function automatic void expect_of(input int brk, input logic [15:0] vol,
                                      output logic [1:0] c, output logic [15:0] d);
        if (brk == 0) begin
            c = C_O;
            d = 16'hFFFF;
        end else begin
            d = 16'(brk);
            if (vol <= 16'd300)  c = C_S;
            else if (brk < 50)   c = C_A;
            else                 c = C_N;
        end
    endfunction

    // Model state: consecutive SHORT / non-SHORT runs, flag, per-class counts.
    bit          armed = 1'b0;
    int          run_s = 0, run_n = 0;
    logic        exp_flag = 1'b0;
    bit          pend_vld = 1'b0;
    logic [1:0]  pend_cls = 2'b00;
    logic [15:0] exp_cnt [4] = '{16'd0, 16'd0, 16'd0, 16'd0};

    always @(negedge clk) begin
        if (armed) begin
            rpt_t r;
            bit   exp_v;
            // Effects of the edge just taken.
            if (!st_q) begin
                run_s    = 0;
                run_n    = 0;
                exp_flag = 1'b0;
            end else if (pend_vld) begin
                if (pend_cls == C_S) begin
                    run_s++;
                    run_n = 0;
                    if (run_s >= 3) exp_flag = 1'b1;
                end else begin
                    run_n++;
                    run_s = 0;
                    if (run_n >= 5) exp_flag = 1'b0;
                end
            end
            if (sc_q) begin
                for (int k = 0; k < 4; k++) exp_cnt[k] = 16'd0;
            end else if (pend_vld && exp_cnt[pend_cls] != 16'hFFFF) begin
                exp_cnt[pend_cls] = exp_cnt[pend_cls] + 16'd1;
            end
            pend_vld = 1'b0;

            chk("short_flag", 32'(pro1_short_flag), 32'(exp_flag));
            exp_v = (rq.size() > 0) && (rq[0].cyc == cyc);
            chk("pulse_valid", 32'(pulse_valid), 32'(exp_v));
            if (exp_v) begin
                r = rq.pop_front();
                chk("pulse_class", 32'(pulse_class), 32'(r.cls));
                chk("ign_delay", 32'(ign_delay), 32'(r.dly));
                pend_vld = 1'b1;
                pend_cls = r.cls;
            end
`ifdef PULSE_SORT_STATS_EN
            chk("cnt_normal", 32'(cnt_normal), 32'(exp_cnt[0]));
            chk("cnt_arc",    32'(cnt_arc),    32'(exp_cnt[1]));
            chk("cnt_short",  32'(cnt_short),  32'(exp_cnt[2]));
            chk("cnt_open",   32'(cnt_open),   32'(exp_cnt[3]));
`endif
        end
    end

    // Sample that can never count as breakdown (valid ones stay below 400).
    task automatic drive_quiet();
        sample_valid = 1'($urandom_range(0, 1));
        if (sample_valid)
            sample_data[31:16] = ($urandom_range(0, 7) == 0) ? 16'd399 : 16'($urandom_range(0, 399));
        else
            sample_data[31:16] = 16'($urandom_range(0, 65535));
        sample_data[15:0] = 16'($urandom_range(0, 65535));
    endtask

    task automatic drive_any();
        sample_valid = 1'($urandom_range(0, 1));
        sample_data  = {16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535))};
    endtask

    // One on-window of len cycles, breakdown sample at offset brk (0 = none,
    // len = coincident with the fall), then gap idle cycles.
    task automatic pulse(input int len, input int brk, input logic [15:0] cur,
                         input logic [15:0] vol, input int gap, input bit sclr);
        int   n0;
        rpt_t r;
        @(negedge clk);
        n0 = cyc;
        for (int o = 0; o <= len; o++) begin
            if (o > 0) @(negedge clk);
            pwm_on = (o < len);
            if (brk != 0 && o == brk) begin
                sample_valid = 1'b1;
                sample_data  = {cur, vol};
            end else if (o == 0 || (brk != 0 && o > brk)) begin
                drive_any();
            end else begin
                drive_quiet();
            end
        end
        r.cyc = n0 + len + 1;
        expect_of(brk, vol, r.cls, r.dly);
        rq.push_back(r);
        for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            pwm_on    = 1'b0;
            stats_clr = sclr && (g == 0);
            drive_any();
        end
        stats_clr = 1'b0;
    endtask

    // Pulse that loses start at offset drop: must vanish without a report.
    task automatic abort_pulse(input int brk, input int drop);
        @(negedge clk);
        for (int o = 0; o <= drop; o++) begin
            if (o > 0) @(negedge clk);
            pwm_on = 1'b1;
            start  = (o < drop);
            if (o == brk) begin
                sample_valid = 1'b1;
                sample_data  = {16'd500, 16'd600};
            end else if (o == 0 || o > brk) begin
                drive_any();
            end else begin
                drive_quiet();
            end
        end
        @(negedge clk);
        pwm_on = 1'b0;
        drive_any();
        @(negedge clk);
        start = 1'b1;
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        pwm_on       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 32'd0;
        stats_clr    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pulse_valid", 32'(pulse_valid), 32'd0);
        chk("rst_pulse_class", 32'(pulse_class), 32'd0);
        chk("rst_ign_delay", 32'(ign_delay), 32'd0);
        chk("rst_flag", 32'(pro1_short_flag), 32'd0);
        rst_n = 1'b1;
        armed = 1'b1;
        @(negedge clk);
        start = 1'b1;
        repeat (2) @(negedge clk);

        // Basic classes.
        pulse(200, 80, 16'd500, 16'd600, 3, 1'b0);
        chk("t1_class", 32'(pulse_class), 32'(C_N));
        chk("t1_delay", 32'(ign_delay), 32'd80);
        pulse(200, 20, 16'd500, 16'd600, 3, 1'b0);
        chk("t2_arc_class", 32'(pulse_class), 32'(C_A));
        chk("t2_arc_delay", 32'(ign_delay), 32'd20);
        pulse(200, 20, 16'd500, 16'd200, 3, 1'b0);
        chk("t2_short_class", 32'(pulse_class), 32'(C_S));
        // Thresholds: current exactly 400, delay 49/50, voltage 300.
        pulse(60, 49, 16'd400, 16'd301, 3, 1'b0);
        chk("arc_edge_49", 32'(pulse_class), 32'(C_A));
        pulse(60, 50, 16'd400, 16'd301, 3, 1'b0);
        chk("normal_edge_50", 32'(pulse_class), 32'(C_N));
        pulse(100, 80, 16'd500, 16'd300, 3, 1'b0);
        chk("short_edge_300", 32'(pulse_class), 32'(C_S));
        // Breakdown on the same cycle pwm_on drops.
        pulse(30, 30, 16'd500, 16'd600, 3, 1'b0);
        chk("coincident_class", 32'(pulse_class), 32'(C_A));
        chk("coincident_delay", 32'(ign_delay), 32'd30);
        // Open gap.
        pulse(200, 0, 16'd0, 16'd0, 3, 1'b0);
        chk("t3_class", 32'(pulse_class), 32'(C_O));
        chk("t3_delay", 32'(ign_delay), 32'hFFFF);
        chk("t3_flag", 32'(pro1_short_flag), 32'd0);

        // Hysteresis.
        pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        pulse(40, 10, 16'd500, 16'd600, 3, 1'b0);
        pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        chk("t4_flag_5th", 32'(pro1_short_flag), 32'd0);
        pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        chk("t4_flag_6th", 32'(pro1_short_flag), 32'd1);
        repeat (4) pulse(100, 70, 16'd500, 16'd600, 3, 1'b0);
        chk("t4_flag_4_normal", 32'(pro1_short_flag), 32'd1);
        pulse(100, 70, 16'd500, 16'd600, 3, 1'b0);
        chk("t4_flag_5_normal", 32'(pro1_short_flag), 32'd0);

        // Abort while ignited.
        repeat (3) pulse(40, 10, 16'd500, 16'd200, 3, 1'b0);
        chk("t5_flag_set", 32'(pro1_short_flag), 32'd1);
        abort_pulse(30, 60);
        chk("t5_flag_cleared", 32'(pro1_short_flag), 32'd0);
        pulse(200, 80, 16'd500, 16'd600, 3, 1'b0);
        chk("t5_next_class", 32'(pulse_class), 32'(C_N));
        chk("t5_next_delay", 32'(ign_delay), 32'd80);

`ifdef PULSE_SORT_STATS_EN
        pulse(30, 0, 16'd0, 16'd0, 3, 1'b1);
        chk("t6_open_cleared", 32'(cnt_open), 32'd0);
        repeat (3) pulse(40, 10, 16'd500, 16'd600, 3, 1'b0);
        chk("t6_arc_3", 32'(cnt_arc), 32'd3);
        pulse(40, 10, 16'd500, 16'd600, 3, 1'b1);
        chk("t6_arc_clr", 32'(cnt_arc), 32'd0);
`endif

        // Randomized pulses, including back-to-back, aborts and stats clears.
        for (int i = 0; i < 200; i++) begin
            int          len, brk, gap, rsel;
            logic [15:0] vol, cur;
            bit          sclr;
            if ($urandom_range(0, 14) == 0) begin
                len = $urandom_range(5, 60);
                abort_pulse($urandom_range(1, len), $urandom_range(1, len - 1));
            end else begin
                len  = $urandom_range(2, 120);
                rsel = $urandom_range(0, 9);
                if (rsel < 2)                    brk = 0;
                else if (rsel < 4 && len >= 56)  brk = $urandom_range(45, 55);
                else                             brk = $urandom_range(1, len);
                vol  = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(295, 305))
                                                   : 16'($urandom_range(0, 2000));
                cur  = ($urandom_range(0, 3) == 0) ? 16'd400 : 16'($urandom_range(400, 65535));
                gap  = $urandom_range(0, 4);
                sclr = (gap > 0) && ($urandom_range(0, 15) == 0);
                pulse(len, brk, cur, vol, gap, sclr);
            end
        end

        pwm_on = 1'b0;
        repeat (6) @(negedge clk);
        chk("reports_drained", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
